// File: rtl/idm_arb.sv
// idm_arb: unified I/D memory, round-robin arbiter, programmable wait states.
// Define IDM_BOUNDS_CHECK_EN for out-of-range detection instead of wrapping.
module idm_arb #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IA,
    output logic              IGnt,
    output logic [DATA_W-1:0] IRD,
    output logic              IValid,
    output logic              IErr,
    input  logic              DReq,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DA,
    input  logic [DATA_W-1:0] WD,
    output logic              DGnt,
    output logic [DATA_W-1:0] RD,
    output logic              DValid,
    output logic              DErr
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned EXT_W = (ADDR_W > 32) ? ADDR_W : 32;
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    if (DEPTH < 2) begin : g_chk_depth
        $error("idm_arb: DEPTH must be at least 2");
    end
    if (WAIT_STATES > 15) begin : g_chk_ws
        $error("idm_arb: WAIT_STATES must be 0..15");
    end
    if (ADDR_W < AW) begin : g_chk_aw
        $error("idm_arb: ADDR_W too narrow for DEPTH");
    end
`ifndef IDM_BOUNDS_CHECK_EN
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_chk_pow2
        $error("idm_arb: DEPTH must be a power of 2 when addresses wrap");
    end
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                last_d_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                port_q;
    logic                we_q;
    logic [DATA_W-1:0]   wd_q;
    logic [DATA_W-1:0]   ird_q;
    logic [DATA_W-1:0]   rd_q;
    logic                ivalid_q;
    logic                dvalid_q;
    logic                ierr_q;
    logic                derr_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                idle;
    logic                ignt;
    logic                dgnt;
    logic                acc_fire;
    logic                acc_port;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wd;
    logic                oob;
    logic [AW-1:0]       idx;
    logic [DATA_W-1:0]   rdata;
    logic [DATA_W-1:0]   resp;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] = DATA_W'(i);
        end
    end

    // Round-robin: on a conflict the port not granted last time wins.
    assign idle = (state_q == S_IDLE) && rst_n;
    assign dgnt = idle && DReq && (!IReq || !last_d_q);
    assign ignt = idle && IReq && (!DReq || last_d_q);

    // With no wait states the acceptance edge is also the access edge.
    always_comb begin
        acc_fire = (state_q == S_WAIT) && (cnt_q == 4'd1);
        acc_port = port_q;
        acc_we   = we_q;
        acc_addr = addr_q;
        acc_wd   = wd_q;
        if (WAIT_STATES == 0) begin
            acc_fire = ignt || dgnt;
            acc_port = dgnt;
            acc_we   = dgnt && MemWrite;
            acc_addr = dgnt ? DA : IA;
            acc_wd   = WD;
        end
    end

`ifdef IDM_BOUNDS_CHECK_EN
    assign oob = EXT_W'(acc_addr) >= EXT_W'(DEPTH);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^acc_addr;
    assign oob            = 1'b0;
`endif

    assign idx   = acc_addr[AW-1:0];
    assign rdata = oob ? '0 : mem_q[idx];
    assign resp  = acc_we ? (oob ? '0 : acc_wd) : rdata;

    always @(posedge clk) begin
        if (rst_n && acc_fire && acc_we && !oob) begin
            mem_q[idx] <= acc_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            wd_q     <= '0;
            ird_q    <= '0;
            rd_q     <= '0;
            ivalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            ierr_q   <= 1'b0;
            derr_q   <= 1'b0;
        end else begin
            ivalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            ierr_q   <= 1'b0;
            derr_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (ignt || dgnt) begin
                        addr_q   <= dgnt ? DA : IA;
                        port_q   <= dgnt;
                        we_q     <= dgnt && MemWrite;
                        wd_q     <= WD;
                        cnt_q    <= WS;
                        last_d_q <= dgnt;
                        state_q  <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            if (acc_fire) begin
                if (acc_port) begin
                    rd_q     <= resp;
                    dvalid_q <= 1'b1;
                    derr_q   <= oob;
                end else begin
                    ird_q    <= resp;
                    ivalid_q <= 1'b1;
                    ierr_q   <= oob;
                end
            end
        end
    end

    assign IGnt   = ignt;
    assign DGnt   = dgnt;
    assign IRD    = ird_q;
    assign RD     = rd_q;
    assign IValid = ivalid_q;
    assign DValid = dvalid_q;
    assign IErr   = ierr_q;
    assign DErr   = derr_q;

endmodule

// File: tb/tb_idm_arb.sv
// tb_idm_arb: directed scoreboard bench for idm_arb.
// Three instances with WAIT_STATES of 0, 2 and 3 share one clock.
module tb_idm_arb;

    logic        clk = 1'b0;
    logic        rst_n    [3];
    logic        IReq     [3];
    logic [15:0] IA       [3];
    logic        IGnt     [3];
    logic [15:0] IRD      [3];
    logic        IValid   [3];
    logic        IErr     [3];
    logic        DReq     [3];
    logic        MemWrite [3];
    logic [15:0] DA       [3];
    logic [15:0] WD       [3];
    logic        DGnt     [3];
    logic [15:0] RD       [3];
    logic        DValid   [3];
    logic        DErr     [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WSV = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        idm_arb #(
            .DATA_W(16), .DEPTH(64), .ADDR_W(16), .WAIT_STATES(WSV)
        ) u_dut (
            .clk(clk), .rst_n(rst_n[g]),
            .IReq(IReq[g]), .IA(IA[g]), .IGnt(IGnt[g]),
            .IRD(IRD[g]), .IValid(IValid[g]), .IErr(IErr[g]),
            .DReq(DReq[g]), .MemWrite(MemWrite[g]), .DA(DA[g]),
            .WD(WD[g]), .DGnt(DGnt[g]), .RD(RD[g]),
            .DValid(DValid[g]), .DErr(DErr[g])
        );
    end

    typedef struct {
        bit          d;
        logic [15:0] data;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input int k, input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_dvalid"}, 32'(DValid[k]), 32'(e.d));
        chk({tag, "_ivalid"}, 32'(IValid[k]), 32'(!e.d));
        chk({tag, "_data"}, 32'(e.d ? RD[k] : IRD[k]), 32'(e.data));
        chk({tag, "_err"}, 32'(e.d ? DErr[k] : IErr[k]), 32'(e.err));
    endtask

    task automatic access(input int k, input bit d, input bit we,
                          input logic [15:0] a, input logic [15:0] wd,
                          input logic [15:0] exp_data, input bit exp_err,
                          input string tag);
        int n;
        exp_t e;
        if (d) begin
            DReq[k] = 1'b1; MemWrite[k] = we; DA[k] = a; WD[k] = wd;
        end else begin
            IReq[k] = 1'b1; IA[k] = a;
        end
        #1;
        n = 0;
        while (!(d ? DGnt[k] : IGnt[k]) && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_gnt_seen"}, 32'(n < 20), 1);
        e.d = d; e.data = exp_data; e.err = exp_err;
        sb.push_back(e);
        tick();
        DReq[k] = 1'b0;
        IReq[k] = 1'b0;
        MemWrite[k] = 1'b0;
        n = 0;
        while (!(IValid[k] || DValid[k]) && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(ws_of(k)));
        pop_check(k, tag);
        tick();
        chk({tag, "_pulse_end"}, 32'(IValid[k] || DValid[k]), 0);
    endtask

    initial begin
        int   ngnt;
        int   nval;
        int   seen;
        bit   gord[$];
        exp_t e;

        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; IReq[k] = 1'b1; DReq[k] = 1'b1;
            IA[k] = '0; DA[k] = '0; WD[k] = '0; MemWrite[k] = 1'b0;
        end
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("rst_gnt", 32'({IGnt[k], DGnt[k]}), 0);
            chk("rst_data", 32'({IRD[k], RD[k]}), 0);
            chk("rst_flags", 32'({IValid[k], DValid[k], IErr[k], DErr[k]}), 0);
            IReq[k] = 1'b0; DReq[k] = 1'b0;
        end
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        tick();

        access(0, 1'b0, 1'b0, 16'd5, 16'h0, 16'd5, 1'b0, "fetch5");
        chk("fetch5_rd_hold", 32'(RD[0]), 0);

        access(2, 1'b1, 1'b1, 16'd10, 16'hBEEF, 16'hBEEF, 1'b0, "st10");
        access(2, 1'b1, 1'b0, 16'd10, 16'h0, 16'hBEEF, 1'b0, "ld10");
        chk("ld10_ird_hold", 32'(IRD[2]), 0);

        gord = '{1'b1, 1'b0, 1'b1, 1'b0};
        IA[0] = 16'd3; DA[0] = 16'd7; MemWrite[0] = 1'b0;
        IReq[0] = 1'b1; DReq[0] = 1'b1;
        #1;
        ngnt = 0;
        nval = 0;
        for (int c = 0; c < 40 && nval < 4; c++) begin
            if (IValid[0] || DValid[0]) begin
                pop_check(0, "rr_resp");
                nval++;
            end
            if (IGnt[0] || DGnt[0]) begin
                chk("rr_one_gnt", 32'(IGnt[0] && DGnt[0]), 0);
                if (gord.size() != 0) begin
                    chk("rr_order", 32'(DGnt[0]), 32'(gord.pop_front()));
                end
                e.d = DGnt[0];
                e.data = DGnt[0] ? 16'd7 : 16'd3;
                e.err = 1'b0;
                sb.push_back(e);
                ngnt++;
            end
            tick();
            if (ngnt >= 4) begin
                IReq[0] = 1'b0;
                DReq[0] = 1'b0;
            end
        end
        chk("rr_nval", 32'(nval), 4);
        chk("rr_ngnt", 32'(ngnt), 4);
        tick();

        DReq[1] = 1'b1; MemWrite[1] = 1'b1; DA[1] = 16'd20; WD[1] = 16'h1234;
        #1;
        seen = 0;
        while (!DGnt[1] && seen < 20) begin
            tick();
            seen++;
        end
        chk("rstmid_gnt_seen", 32'(seen < 20), 1);
        tick();
        DReq[1] = 1'b0; MemWrite[1] = 1'b0;
        tick();
        rst_n[1] = 1'b0;
        #1;
        chk("rstmid_gnt_low", 32'(DGnt[1]), 0);
        tick();
        rst_n[1] = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (DValid[1] || IValid[1]) seen++;
            tick();
        end
        chk("rstmid_no_valid", 32'(seen), 0);
        access(1, 1'b1, 1'b0, 16'd20, 16'h0, 16'd20, 1'b0, "ld20");

`ifdef IDM_BOUNDS_CHECK_EN
        access(2, 1'b1, 1'b0, 16'd64, 16'h0, 16'h0, 1'b1, "ld64_oob");
        access(2, 1'b1, 1'b1, 16'd64, 16'hAAAA, 16'h0, 1'b1, "st64_oob");
        access(2, 1'b1, 1'b0, 16'd0, 16'h0, 16'h0, 1'b0, "ld0_after");
`else
        access(2, 1'b1, 1'b0, 16'd65, 16'h0, 16'd1, 1'b0, "ld65_wrap");
`endif

        chk("sb_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
